// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_mux
// Purpose  : 4-digit common-anode 7-segment scan driver with dead-time and
//            optional leading-zero blanking; feeds a hex-to-7-seg decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int DIV  = 50000,
    parameter int DEAD = 2
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [15:0] valIn,
    input  logic [3:0]  dpIn,
    input  logic        loadIn,
    input  logic        blankLzIn,
    output logic [3:0]  hexOut,
    output logic        dpOut,
    output logic [3:0]  digSelOut,
    output logic        slotOut
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;

    logic          w_last;
    logic          w_dead;
    logic [3:0]    w_lit;
    logic [3:0]    w_blank;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
        end else begin
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (loadIn) begin
                r_shadow_val <= valIn;
                r_shadow_dp  <= dpIn;
            end
        end
    end

    assign w_last  = (r_cnt == C_LAST);
    assign slotOut = w_last;

    // A zero-length dead window would make the compare constant, so skip it.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            localparam logic [CW-1:0] C_DEAD = CW'(DEAD);
            assign w_dead = (r_cnt < C_DEAD);
        end
    endgenerate

    // A digit must stay lit if its nibble is non-zero or its dp is requested.
    assign w_lit[3] = (r_shadow_val[15:12] != 4'h0) | r_shadow_dp[3];
    assign w_lit[2] = (r_shadow_val[11:8]  != 4'h0) | r_shadow_dp[2];
    assign w_lit[1] = (r_shadow_val[7:4]   != 4'h0) | r_shadow_dp[1];
    assign w_lit[0] = 1'b1;

    assign w_blank[3] = ~w_lit[3];
    assign w_blank[2] = w_blank[3] & ~w_lit[2];
    assign w_blank[1] = w_blank[2] & ~w_lit[1];
    assign w_blank[0] = 1'b0;

    always_comb begin
        hexOut = r_shadow_val[3:0];
        case (r_idx)
            2'd0: hexOut = r_shadow_val[3:0];
            2'd1: hexOut = r_shadow_val[7:4];
            2'd2: hexOut = r_shadow_val[11:8];
            2'd3: hexOut = r_shadow_val[15:12];
            default: hexOut = r_shadow_val[3:0];
        endcase
    end

    assign dpOut = ~r_shadow_dp[r_idx];

    always_comb begin
        digSelOut = 4'b1111;
        if (!(w_dead || (blankLzIn && w_blank[r_idx]))) begin
            digSelOut = ~(4'b0001 << r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_mux
// Purpose  : Directed self-checking bench for seg7_scan_mux (DIV=8/DEAD=2 and
//            DIV=2/DEAD=0 instances sharing clock and stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;

    logic        clk;
    logic        rst;
    logic [15:0] val;
    logic [3:0]  dp;
    logic        load;
    logic        blank;

    logic [3:0]  hex_a, sel_a, hex_b, sel_b;
    logic        dp_a, slot_a, dp_b, slot_b;

    int n_tests;
    int n_fail;
    int t;

    seg7_scan_mux #(.DIV(8), .DEAD(2)) u_dut_a (
        .clkIn(clk), .rstIn(rst), .valIn(val), .dpIn(dp), .loadIn(load),
        .blankLzIn(blank), .hexOut(hex_a), .dpOut(dp_a),
        .digSelOut(sel_a), .slotOut(slot_a)
    );

    seg7_scan_mux #(.DIV(2), .DEAD(0)) u_dut_b (
        .clkIn(clk), .rstIn(rst), .valIn(val), .dpIn(dp), .loadIn(load),
        .blankLzIn(blank), .hexOut(hex_b), .dpOut(dp_b),
        .digSelOut(sel_b), .slotOut(slot_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    function automatic int cnt_m();
        return t % 8;
    endfunction

    function automatic int idx_m();
        return (t / 8) % 4;
    endfunction

    function automatic logic [3:0] exp_sel(input int c, input int i, input bit blanked);
        logic [3:0] one;
        one = 4'b0001;
        if (c < 2 || blanked) return 4'b1111;
        return ~(one << i);
    endfunction

    task automatic run_to(input int i, input int c);
        int guard;
        guard = 0;
        while (!(idx_m() == i && cnt_m() == c) && guard < 40) begin
            step();
            guard++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        val  = v;
        dp   = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    logic [15:0] nib_v;
    logic [3:0]  dp_v;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        t       = 0;
        rst = 1'b1; val = 16'h0; dp = 4'h0; load = 1'b0; blank = 1'b0;
        step();
        step();
        t = 0;
        chk("rst_sel",  {12'h0, sel_a},  16'h000F);
        chk("rst_hex",  {12'h0, hex_a},  16'h0000);
        chk("rst_dp",   {15'h0, dp_a},   16'h0001);
        chk("rst_slot", {15'h0, slot_a}, 16'h0000);
        rst = 1'b0;

        // Idle scan: anode sequence, slot pulse, and fast no-dead instance.
        for (int k = 0; k < 40; k++) begin
            chk("idle_sel",   {12'h0, sel_a},  {12'h0, exp_sel(cnt_m(), idx_m(), 1'b0)});
            chk("idle_slot",  {15'h0, slot_a}, {15'h0, (cnt_m() == 7)});
            chk("idle_hex",   {12'h0, hex_a},  16'h0000);
            chk("fast_sel",   {12'h0, sel_b},  {12'h0, ~(4'b0001 << ((t / 2) % 4))});
            chk("fast_slot",  {15'h0, slot_b}, {15'h0, (t % 2 == 1)});
            step();
        end

        // 12AF with dp on digit 2, no blanking.
        nib_v = 16'h12AF;
        dp_v  = 4'b0100;
        do_load(nib_v, dp_v);
        for (int k = 0; k < 8; k++) begin
            run_to(k % 4, 4);
            chk("val_hex", {12'h0, hex_a}, {12'h0, nib_v[4*(k%4) +: 4]});
            chk("val_dp",  {15'h0, dp_a},  {15'h0, ~dp_v[k%4]});
            chk("val_sel", {12'h0, sel_a}, {12'h0, exp_sel(4, k % 4, 1'b0)});
            step();
        end

        // Leading-zero blanking of 0005.
        blank = 1'b1;
        do_load(16'h0005, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            run_to(k % 4, 4);
            chk("lz5_sel", {12'h0, sel_a}, {12'h0, (k % 4 == 0) ? 4'b1110 : 4'b1111});
            step();
        end
        run_to(0, 4);
        chk("lz5_hex", {12'h0, hex_a}, 16'h0005);
        run_to(0, 1);
        chk("lz5_dead", {12'h0, sel_a}, 16'h000F);

        do_load(16'h0000, 4'b0000);
        run_to(0, 4);
        chk("lz0_sel", {12'h0, sel_a}, 16'h000E);
        chk("lz0_hex", {12'h0, hex_a}, 16'h0000);

        // 0030 with dp on digit 2: only digit 3 blanked.
        do_load(16'h0030, 4'b0100);
        for (int k = 1; k <= 4; k++) begin
            run_to(k % 4, 4);
            chk("lz30_sel", {12'h0, sel_a},
                {12'h0, (k == 3) ? 4'b1111 : ~(4'b0001 << (k % 4))});
            step();
        end

        // Load coinciding with slot change.
        run_to(1, 7);
        chk("edge_slot", {15'h0, slot_a}, 16'h0001);
        blank = 1'b0;
        do_load(16'h4321, 4'b0000);
        chk("edge_hex", {12'h0, hex_a}, 16'h0003);
        chk("edge_cnt_sel", {12'h0, sel_a}, 16'h000F);

        // Mid-slot blanking toggle acts without a clock edge.
        blank = 1'b1;
        do_load(16'h0030, 4'b0000);
        run_to(3, 4);
        chk("tog_on", {12'h0, sel_a}, 16'h000F);
        blank = 1'b0;
        #1;
        chk("tog_off", {12'h0, sel_a}, 16'h0007);
        blank = 1'b1;
        #1;
        chk("tog_on2", {12'h0, sel_a}, 16'h000F);

        // Mid-slot reset at idx 2, cnt 5.
        blank = 1'b0;
        do_load(16'h9876, 4'b1111);
        run_to(2, 5);
        chk("pre_rst_hex", {12'h0, hex_a}, 16'h0008);
        rst = 1'b1;
        step();
        t = 0;
        rst = 1'b0;
        chk("mrst_sel",  {12'h0, sel_a},  16'h000F);
        chk("mrst_hex",  {12'h0, hex_a},  16'h0000);
        chk("mrst_dp",   {15'h0, dp_a},   16'h0001);
        chk("mrst_slot", {15'h0, slot_a}, 16'h0000);
        run_to(0, 2);
        chk("mrst_sel0", {12'h0, sel_a}, 16'h000E);
        run_to(2, 4);
        chk("mrst_hex2", {12'h0, hex_a}, 16'h0000);
        chk("mrst_dp2",  {15'h0, dp_a},  16'h0001);
        chk("mrst_sel2", {12'h0, sel_a}, 16'h000B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
